// File: rtl/sram_port_ctrl_if.sv
// rtl/sram_port_ctrl_if.sv - request/response handshake bundle between a requester and sram_port_ctrl
interface sram_port_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - single-port SRAM front end with response buffer, EMA register and idle retention
module sram_port_ctrl #(
    parameter int          ADDR_W      = 11,
    parameter int          DATA_W      = 32,
    parameter int          IDLE_CYCLES = 64,
    parameter int          WAKE_CYCLES = 2,
    parameter logic [2:0]  EMA_DEFAULT = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    sram_port_ctrl_if.slave   bus,
    input  logic              ema_we,
    input  logic [2:0]        ema_cfg,
    input  logic              sleep_en,
    output logic              busy,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic [2:0]        sram_ema,
    output logic              sram_retn
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDLE_W-1:0] idle_cnt;
    logic [WAKE_W-1:0] wake_cnt;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              rd_pending;

    logic              wen_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic [2:0]        ema_q;

    logic              accept;
    logic              pop;
    logic              push;
    logic [2:0]        occupancy;
    logic              idle_cond;
    logic              idle_done;
    logic              wake_done;

    // Slots already promised: buffered entries plus the read in flight, less the one leaving now.
    assign occupancy     = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};
    assign bus.req_ready = rst & (state == ACTIVE) & ~ema_we & (occupancy < 3'd2);
    assign accept        = bus.req_valid & bus.req_ready;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign push          = rd_pending;

    assign bus.rsp_valid = (count != 2'd0);
    assign bus.rsp_rdata = fifo_mem[rd_ptr];

    assign busy = rd_pending | (count != 2'd0) | (state == WAKE);

    // Pins follow the request during an access and otherwise hold the last access.
    assign sram_cen = ~accept;
    assign sram_wen = accept ? ~bus.req_we   : wen_q;
    assign sram_a   = accept ? bus.req_addr  : a_q;
    assign sram_d   = accept ? bus.req_wdata : d_q;
    assign sram_ema = ema_q;

    assign idle_cond = (state == ACTIVE) & sleep_en & ~accept & ~rd_pending & (count == 2'd0);
    assign idle_done = idle_cond & (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
    assign wake_done = (wake_cnt == WAKE_W'(WAKE_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ACTIVE;
        else      state <= state_nxt;
    end

    // Next-state logic and retention pin.
    always_comb begin
        state_nxt = state;
        sram_retn = 1'b1;
        case (state)
            ACTIVE: if (idle_done) state_nxt = SLEEP;
            SLEEP: begin
                sram_retn = 1'b0;
                if (bus.req_valid || !sleep_en) state_nxt = WAKE;
            end
            WAKE:   if (wake_done) state_nxt = ACTIVE;
            default: state_nxt = ACTIVE;
        endcase
    end

    // Consecutive idle cycles while sleep is permitted.
    always_ff @(posedge clk) begin
        if (!rst)           idle_cnt <= '0;
        else if (idle_cond) idle_cnt <= idle_cnt + IDLE_W'(1);
        else                idle_cnt <= '0;
    end

    // Settling time after RETN is raised, before requests are taken again.
    always_ff @(posedge clk) begin
        if (!rst)                            wake_cnt <= '0;
        else if (state == WAKE && !wake_done) wake_cnt <= wake_cnt + WAKE_W'(1);
        else                                 wake_cnt <= '0;
    end

    // Last-access pin values, so the macro sees stable A/D/WEN between accesses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wen_q <= 1'b1;
            a_q   <= '0;
            d_q   <= '0;
        end else if (accept) begin
            wen_q <= ~bus.req_we;
            a_q   <= bus.req_addr;
            d_q   <= bus.req_wdata;
        end
    end

    // A read accepted now has its data on sram_q one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) rd_pending <= 1'b0;
        else      rd_pending <= accept & ~bus.req_we;
    end

    // Response buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Response buffer storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sram_q;
    end

    // EMA register; ema_we blocks acceptance, so it never changes under an access.
    always_ff @(posedge clk) begin
        if (!rst)        ema_q <= EMA_DEFAULT;
        else if (ema_we) ema_q <= ema_cfg;
    end

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Front-end controller that owns the pins of one single-port SRAM macro (`sram_sp_hdc_svt_rvt_hvt`: CEN/WEN active-low, 11-bit A, 32-bit D/Q, EMA, RETN). It accepts read/write requests on a valid/ready interface and drives the macro. It returns read data through a 2-entry response buffer that tolerates backpressure. It also places the macro in retention after a programmable idle period. Vector-unit load/store logic talks to this block rather than to the macro directly.

## Interface
- ADDR_W, 11, macro address width
- DATA_W, 32, macro data width
- IDLE_CYCLES, 64, consecutive idle cycles before entering retention (≥1)
- WAKE_CYCLES, 2, cycles with RETN=1 and CEN=1 before accepting after retention (≥1)
- EMA_DEFAULT, 3'b000, EMA value after reset

Ports:
- clk  in  1  single clock; the macro and this block both sample on its rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data present
- rsp_ready  in  1  consumer takes the data
- rsp_rdata  out  DATA_W  read data, returned in request order
- ema_we  in  1  load ema_cfg into the EMA register
- ema_cfg  in  3  new EMA value
- sleep_en  in  1  permits entry into retention
- busy  out  1  read pending, response buffer non-empty, or state WAKE
- sram_cen, sram_wen  out  1 each  macro CEN/WEN (active-low)
- sram_a  out  ADDR_W;  sram_d  out  DATA_W;  sram_q  in  DATA_W
- sram_ema  out  3;  sram_retn  out  1

## Operation
- FSM states: ACTIVE, SLEEP, WAKE. Reset enters ACTIVE.
- Macro pins are combinational from the request:
  - sram_cen = ~(req_valid & req_ready); sram_wen = ~req_we; sram_a = req_addr; sram_d = req_wdata.
  - When no access occurs, sram_a, sram_d and sram_wen hold their previous values.
- req_ready = rst & (state==ACTIVE) & ~ema_we & (count + rd_pending − pop < 2).
  - count: entries in the response FIFO (0..2).
  - rd_pending: a read was accepted at the previous edge.
  - pop = rsp_valid & rsp_ready.
  - req_ready never depends on req_valid or req_we.
- Accepted read: rd_pending is set. At the next edge sram_q is pushed into the FIFO and rd_pending clears, unless another read is accepted in the same cycle.
- Writes produce no response.
- rsp_valid = (count != 0). rsp_rdata = FIFO head. A push and a pop in the same cycle leave count unchanged.
- Idle counter:
  - Increments in ACTIVE when all of the following hold: sleep_en=1, no acceptance, rd_pending=0, count=0.
  - Otherwise it clears.
  - When it reaches IDLE_CYCLES the FSM goes to SLEEP.
- SLEEP: sram_retn=0, sram_cen=1, req_ready=0. If req_valid=1 or sleep_en=0, the FSM goes to WAKE.
- WAKE: sram_retn=1, sram_cen=1, req_ready=0. A counter runs WAKE_CYCLES cycles, then the FSM returns to ACTIVE.
- EMA register: loaded from ema_cfg at the edge where ema_we=1, in any state. req_ready is 0 in that cycle, so EMA never changes during an access.
- sram_ema is driven from the EMA register.

## Timing
- Reset values: state ACTIVE, counters 0, FIFO empty, rd_pending 0, rsp_valid 0, busy 0, sram_cen 1, sram_wen 1, sram_a 0, sram_d 0, sram_retn 1, sram_ema EMA_DEFAULT. req_ready is 0 while rst=0.
- Read latency: if a request is accepted in cycle A, sram_q is valid in A+1 and rsp_valid rises in A+2.
- Write: the macro is written at the edge that ends the acceptance cycle.
- Throughput: with rsp_ready held 1, one read or write is accepted per cycle indefinitely.
- Backpressure: with rsp_ready=0, at most 2 reads are outstanding (FIFO plus pending). Data is never dropped or reordered.
- Retention entry: SLEEP begins at the edge where the counter reaches IDLE_CYCLES, and sram_retn=0 from the next cycle.
- Retention exit: the first acceptance is possible WAKE_CYCLES+1 cycles after the wake condition.
- Reset mid-operation:
  - The pending read and all FIFO contents are discarded; rsp_valid=0 in the cycle after the reset edge.
  - From SLEEP, reset returns directly to ACTIVE with sram_retn=1.
  - Macro contents are not touched.
- A request held during SLEEP stays unaccepted until ACTIVE. The requester must keep req_valid, req_we, req_addr and req_wdata stable.

## Test plan
- Write 0x0000_000E to 0x00F, then read 0x00F: sram_cen=0/sram_wen=0 in the write cycle; rsp_rdata=0x0000_000E with rsp_valid rising 2 cycles after read acceptance.
- Write 0x11, 0x22, 0x33 to 0x001..0x003, then 3 back-to-back reads with rsp_ready=0: req_ready drops after 2 reads are accepted. Raise rsp_ready: data returns 0x11, 0x22, then the third read is accepted and 0x33 returns, in order.
- 16 back-to-back reads with rsp_ready=1: req_ready stays 1 and rsp_valid stays 1 for 16 consecutive cycles.
- IDLE_CYCLES=8, WAKE_CYCLES=2, sleep_en=1:
  - After 8 idle cycles sram_retn=0.
  - Assert req_valid (read 0x00F): WAKE lasts 2 cycles with sram_retn=1 and cen=1, then the read is accepted and returns 0x0000_000E.
  - Repeat with sleep_en=0: the block never enters SLEEP.
- Assert ema_we with ema_cfg=3'b101 while req_valid=1: req_ready=0 that cycle, sram_ema=3'b101 the next cycle, and the request is accepted the next cycle.
- Accept 2 reads, hold rsp_ready=0, then pulse rst=0 for one cycle: rsp_valid=0, busy=0 and all outputs at reset values. No stale data appears afterward.
